// File: rtl/i2c_slave_regs.sv
// I2C target with a small register file. Oversamples SCL/SDA on the system
// clock, never stretches SCL, drives SDA open-drain from a registered enable.
module i2c_slave_regs #(
  parameter int                    ADDR_WIDTH  = 7,
  parameter logic [ADDR_WIDTH-1:0] DEVICE_ADDR = 7'h11,
  parameter int                    REG_WIDTH   = 8,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    NUM_REGS    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_scl,
  inout  wire                   io_sda,
  input  logic [REG_WIDTH-1:0]  i_host_addr,
  output logic [DATA_WIDTH-1:0] o_host_data,
  output logic                  o_wr_valid,
  output logic [REG_WIDTH-1:0]  o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_busy
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] DEV_ADDR = 4'd1;
  localparam logic [3:0] ADDR_ACK = 4'd2;
  localparam logic [3:0] REG_ADDR = 4'd3;
  localparam logic [3:0] REG_ACK  = 4'd4;
  localparam logic [3:0] WR_DATA  = 4'd5;
  localparam logic [3:0] WR_ACK   = 4'd6;
  localparam logic [3:0] RD_DATA  = 4'd7;
  localparam logic [3:0] RD_ACK   = 4'd8;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [3:0]            state;
  logic [2:0]            bit_cnt;
  logic                  byte_rdy;
  logic                  rw;
  logic                  mack;
  logic                  sda_oe;
  logic [7:0]            shreg;
  logic [DATA_WIDTH-1:0] txsh;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      ptr_inc;
  logic                  shift_state;
  logic                  reg_ok;
  logic                  host_ok;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  assign io_sda = sda_oe ? 1'b0 : 1'bz;

  // Synchronizers plus history flops; reset to the idle-bus level so release
  // of reset cannot fabricate a START/STOP.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= i_scl;  scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= io_sda; sda_s2 <= sda_s1; sda_d <= sda_s2;
    end
  end

  assign scl_rise  =  scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 &  scl_d;
  assign start_det =  scl_s2 &  scl_d & sda_d & ~sda_s2;
  assign stop_det  =  scl_s2 &  scl_d & ~sda_d & sda_s2;

  // Pointer increment modulo NUM_REGS and range checks
  always_comb begin
    ptr_inc = ptr + IDX_W'(1);
    if (int'(ptr) == NUM_REGS - 1) ptr_inc = '0;
    reg_ok      = ({1'b0, shreg} < 9'(NUM_REGS));
    host_ok     = ({1'b0, i_host_addr} < (REG_WIDTH+1)'(NUM_REGS));
    shift_state = (state == DEV_ADDR) || (state == REG_ADDR) ||
                  (state == WR_DATA)  || (state == RD_DATA);
  end

  // Protocol FSM: bits captured on SCL rise, byte decisions and SDA changes on
  // SCL fall. byte_rdy marks that the 8th rise has happened so the following
  // fall acts on the complete byte.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      byte_rdy   <= 1'b0;
      rw         <= 1'b0;
      mack       <= 1'b1;
      sda_oe     <= 1'b0;
      shreg      <= '0;
      txsh       <= '0;
      ptr        <= '0;
      o_busy     <= 1'b0;
      o_wr_valid <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      o_wr_valid <= 1'b0;
      if (start_det) begin
        state    <= DEV_ADDR;
        bit_cnt  <= '0;
        byte_rdy <= 1'b0;
        sda_oe   <= 1'b0;
        o_busy   <= 1'b1;
      end else if (stop_det) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        byte_rdy <= 1'b0;
        sda_oe   <= 1'b0;
        o_busy   <= 1'b0;
      end else begin
        if (scl_rise && shift_state) begin
          shreg   <= {shreg[6:0], sda_s2};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) byte_rdy <= 1'b1;
        end
        if (scl_rise && state == RD_ACK) begin
          mack <= sda_s2;
          if (!sda_s2) ptr <= ptr_inc;
        end
        if (scl_fall) begin
          case (state)
            DEV_ADDR: if (byte_rdy) begin
              byte_rdy <= 1'b0;
              if (shreg[7:1] == DEVICE_ADDR) begin
                rw     <= shreg[0];
                sda_oe <= 1'b1;
                state  <= ADDR_ACK;
              end else begin
                state  <= IDLE;
              end
            end
            ADDR_ACK: if (rw) begin
              txsh   <= regs[ptr];
              sda_oe <= ~regs[ptr][DATA_WIDTH-1];
              state  <= RD_DATA;
            end else begin
              sda_oe <= 1'b0;
              state  <= REG_ADDR;
            end
            REG_ADDR: if (byte_rdy) begin
              byte_rdy <= 1'b0;
              if (reg_ok) begin
                ptr    <= shreg[IDX_W-1:0];
                sda_oe <= 1'b1;
                state  <= REG_ACK;
              end else begin
                state  <= IDLE;
              end
            end
            REG_ACK, WR_ACK: begin
              sda_oe <= 1'b0;
              state  <= WR_DATA;
            end
            WR_DATA: if (byte_rdy) begin
              byte_rdy   <= 1'b0;
              regs[ptr]  <= shreg;
              o_wr_valid <= 1'b1;
              o_wr_addr  <= REG_WIDTH'(ptr);
              o_wr_data  <= shreg;
              ptr        <= ptr_inc;
              sda_oe     <= 1'b1;
              state      <= WR_ACK;
            end
            RD_DATA: if (byte_rdy) begin
              byte_rdy <= 1'b0;
              sda_oe   <= 1'b0;
              state    <= RD_ACK;
            end else begin
              txsh   <= {txsh[DATA_WIDTH-2:0], 1'b0};
              sda_oe <= ~txsh[DATA_WIDTH-2];
            end
            RD_ACK: if (!mack) begin
              txsh   <= regs[ptr];
              sda_oe <= ~regs[ptr][DATA_WIDTH-1];
              state  <= RD_DATA;
            end else begin
              state  <= IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Host-side registered read port; same-cycle bus writes show next cycle
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)     o_host_data <= '0;
    else if (host_ok) o_host_data <= regs[i_host_addr[IDX_W-1:0]];
    else              o_host_data <= '0;
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged bus master drives SCL/SDA,
// monitors record write strobes and any slave drive of SDA.
module tb_i2c_slave_regs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m_scl;
  logic       m_oe;
  logic [7:0] host_addr;
  logic [7:0] host_data;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  wire        sda;

  assign sda = m_oe ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_regs #(.DEVICE_ADDR(7'h11), .NUM_REGS(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_scl       (m_scl),
    .io_sda      (sda),
    .i_host_addr (host_addr),
    .o_host_data (host_data),
    .o_wr_valid  (wr_valid),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_busy      (busy)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int q = 6;

  int         wr_cnt = 0;
  int         drv_cnt = 0;
  logic       cap_next = 1'b0;
  logic [7:0] wa [16];
  logic [7:0] wd [16];
  logic [7:0] hd_at [16];
  logic [7:0] hd_next [16];

  // Record each write strobe cycle and the host read port around it
  always @(negedge clk) begin
    if (cap_next) begin
      if (wr_cnt > 0 && wr_cnt <= 16) hd_next[wr_cnt-1] = host_data;
      cap_next = 1'b0;
    end
    if (wr_valid) begin
      if (wr_cnt < 16) begin
        wa[wr_cnt] = wr_addr; wd[wr_cnt] = wr_data; hd_at[wr_cnt] = host_data;
      end
      wr_cnt++;
      cap_next = 1'b1;
    end
    if (!m_oe && sda === 1'b0) drv_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_oe = 1'b0; wq(q);
    m_scl = 1'b1; wq(2*q);
    m_oe = 1'b1; wq(2*q);
    m_scl = 1'b0; wq(q);
  endtask

  task automatic i2c_stop();
    m_oe = 1'b1; wq(q);
    m_scl = 1'b1; wq(2*q);
    m_oe = 1'b0; wq(2*q);
  endtask

  task automatic write_bit(input logic b);
    m_oe = ~b; wq(q);
    m_scl = 1'b1; wq(2*q);
    m_scl = 1'b0; wq(q);
  endtask

  task automatic read_bit(output logic b);
    m_oe = 1'b0; wq(q);
    m_scl = 1'b1; wq(q);
    b = sda;
    wq(q);
    m_scl = 1'b0; wq(q);
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] v, input logic nack, output logic slot);
    logic b;
    v = '0;
    for (int i = 0; i < 8; i++) begin read_bit(b); v = {v[6:0], b}; end
    if (nack) read_bit(slot);
    else begin write_bit(1'b0); slot = 1'b0; end
  endtask

  task automatic hread(input logic [7:0] a, output logic [7:0] d);
    host_addr = a;
    @(negedge clk);
    d = host_data;
  endtask

  logic       ack;
  logic       slot;
  logic [7:0] d;

  initial begin
    rst_n = 1'b0; m_scl = 1'b1; m_oe = 1'b0; host_addr = '0;
    wq(4);
    chk("rst_sda_released", sda, 1);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    wq(2);
    for (int i = 0; i < 4; i++) begin
      hread(8'(i), d);
      chk("rst_host_data", d, 0);
    end

    // Single write to reg 0
    q = 6;
    host_addr = 8'd0;
    wq(2);
    i2c_start();
    chk("busy_after_start", busy, 1);
    write_byte(8'h22, ack); chk("w1_ack_dev", ack, 0);
    write_byte(8'h00, ack); chk("w1_ack_reg", ack, 0);
    write_byte(8'hDC, ack); chk("w1_ack_data", ack, 0);
    i2c_stop();
    wq(4);
    chk("busy_after_stop", busy, 0);
    chk("w1_strobes", wr_cnt, 1);
    chk("w1_addr", wa[0], 8'h00);
    chk("w1_data", wd[0], 8'hDC);
    chk("w1_host_old_at_strobe", hd_at[0], 8'h00);
    chk("w1_host_new_after", hd_next[0], 8'hDC);
    hread(8'd0, d); chk("w1_host_reg0", d, 8'hDC);

    // Read back with repeated START
    q = 10;
    i2c_start();
    write_byte(8'h22, ack); chk("r1_ack_dev", ack, 0);
    write_byte(8'h00, ack); chk("r1_ack_reg", ack, 0);
    i2c_start();
    chk("r1_busy_through_sr", busy, 1);
    write_byte(8'h23, ack); chk("r1_ack_devrd", ack, 0);
    read_byte(d, 1'b1, slot);
    chk("r1_data", d, 8'hDC);
    chk("r1_nack_slot_released", slot, 1);
    i2c_stop();
    wq(4);
    chk("r1_no_strobe", wr_cnt, 1);

    // Burst write with pointer wrap 3 -> 0 -> 1
    q = 6;
    i2c_start();
    write_byte(8'h22, ack); chk("b_ack_dev", ack, 0);
    write_byte(8'h03, ack); chk("b_ack_reg", ack, 0);
    write_byte(8'h11, ack); chk("b_ack_d0", ack, 0);
    write_byte(8'h22, ack); chk("b_ack_d1", ack, 0);
    write_byte(8'h33, ack); chk("b_ack_d2", ack, 0);
    i2c_stop();
    wq(4);
    chk("b_strobes", wr_cnt, 4);
    chk("b_addr0", wa[1], 8'd3); chk("b_data0", wd[1], 8'h11);
    chk("b_addr1", wa[2], 8'd0); chk("b_data1", wd[2], 8'h22);
    chk("b_addr2", wa[3], 8'd1); chk("b_data2", wd[3], 8'h33);
    hread(8'd3, d); chk("b_host_reg3", d, 8'h11);
    hread(8'd0, d); chk("b_host_reg0", d, 8'h22);
    hread(8'd1, d); chk("b_host_reg1", d, 8'h33);
    hread(8'd2, d); chk("b_host_reg2", d, 8'h00);
    hread(8'd5, d); chk("host_out_of_range", d, 8'h00);

    // Burst read from 3 with wrap
    i2c_start();
    write_byte(8'h22, ack); chk("br_ack_dev", ack, 0);
    write_byte(8'h03, ack); chk("br_ack_reg", ack, 0);
    i2c_start();
    write_byte(8'h23, ack); chk("br_ack_devrd", ack, 0);
    read_byte(d, 1'b0, slot); chk("br_data0", d, 8'h11);
    read_byte(d, 1'b0, slot); chk("br_data1", d, 8'h22);
    read_byte(d, 1'b1, slot); chk("br_data2", d, 8'h33);
    chk("br_nack_slot_released", slot, 1);
    i2c_stop();
    wq(4);

    // Wrong device address: slave must stay silent
    drv_cnt = 0;
    i2c_start();
    write_byte(8'hA0, ack); chk("rej_dev_nack", ack, 1);
    write_byte(8'h00, ack); chk("rej_dev_idle", ack, 1);
    i2c_stop();
    wq(4);
    chk("rej_dev_no_drive", drv_cnt, 0);
    chk("rej_dev_no_strobe", wr_cnt, 4);

    // Out-of-range register address
    i2c_start();
    write_byte(8'h22, ack); chk("rej_reg_ack_dev", ack, 0);
    write_byte(8'h05, ack); chk("rej_reg_nack", ack, 1);
    write_byte(8'h77, ack); chk("rej_reg_data_nack", ack, 1);
    i2c_stop();
    wq(4);
    chk("rej_reg_no_strobe", wr_cnt, 4);
    hread(8'd0, d); chk("rej_reg_reg0_kept", d, 8'h22);
    hread(8'd1, d); chk("rej_reg_reg1_kept", d, 8'h33);

    // Reset while slave drives MSB (0) of reg0 = 0x22
    i2c_start();
    write_byte(8'h22, ack); chk("mr_ack_dev", ack, 0);
    write_byte(8'h00, ack); chk("mr_ack_reg", ack, 0);
    i2c_start();
    write_byte(8'h23, ack); chk("mr_ack_devrd", ack, 0);
    chk("mr_slave_drives_low", sda, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_sda_released", sda, 1);
    chk("mr_busy_clear", busy, 0);
    wq(3);
    rst_n = 1'b1;
    m_scl = 1'b1;
    wq(4);
    hread(8'd0, d); chk("mr_reg0_cleared", d, 8'h00);
    i2c_start();
    write_byte(8'h22, ack); chk("mr_w_ack_dev", ack, 0);
    write_byte(8'h02, ack); chk("mr_w_ack_reg", ack, 0);
    write_byte(8'h5A, ack); chk("mr_w_ack_data", ack, 0);
    i2c_stop();
    wq(4);
    chk("mr_w_strobes", wr_cnt, 5);
    chk("mr_w_addr", wa[4], 8'd2);
    chk("mr_w_data", wd[4], 8'h5A);
    hread(8'd2, d); chk("mr_w_host_reg2", d, 8'h5A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
